// File: rtl/output_deskew_fifo.sv
// Realigns N staggered accumulator lanes into one flat row and queues complete rows in a FWFT FIFO.
// Latency: row is pushed on the edge ending the zero-delay lane's arrival cycle; out_valid the cycle after.
// Backpressure: out_ready stalls only the FIFO; the delay lines never stall, a row arriving when full is dropped.
module output_deskew_fifo #(
   parameter int N       = 2,
   parameter int DW      = 16,
   parameter int DEPTH   = 4,
   parameter int REVERSE = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N-1:0][DW-1:0]         skewed_data_in,
   input  logic [N-1:0]                 skewed_valid_in,
   output logic [N-1:0][DW-1:0]         out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         overflow,
   output logic                         misalign,
   input  logic                         clear_flags
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // Lane data is carried as raw bits: signed values pass through untouched.
   typedef logic [N-1:0][DW-1:0] row_t;

   row_t            dly_dat;
   logic [N-1:0]    dly_vld;
   logic            aligned_vld;
   logic            partial;
   logic            push;
   logic            pop;
   logic            full;
   logic            accept;

   row_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   for (genvar i = 0; i < N; i++) begin : g_lane
      // Early lanes wait longer so every lane of a row lines up with the last one.
      localparam int D = (REVERSE != 0) ? i : (N - 1 - i);
      if (D == 0) begin : g_wire
         assign dly_dat[i] = skewed_data_in[i];
         assign dly_vld[i] = skewed_valid_in[i];
      end else begin : g_sr
         logic [D-1:0][DW-1:0] sr_dat;
         logic [D-1:0]         sr_vld;
         // Free-running shift register for data and valid; reset flushes in-flight lanes.
         always_ff @(posedge clk) begin
            if (rst) begin
               sr_dat <= '0;
               sr_vld <= '0;
            end else begin
               sr_dat[0] <= skewed_data_in[i];
               sr_vld[0] <= skewed_valid_in[i];
               for (int k = 1; k < D; k++) begin
                  sr_dat[k] <= sr_dat[k-1];
                  sr_vld[k] <= sr_vld[k-1];
               end
            end
         end
         assign dly_dat[i] = sr_dat[D-1];
         assign dly_vld[i] = sr_vld[D-1];
      end
   end

   assign aligned_vld = &dly_vld;
   assign partial     = (|dly_vld) & ~aligned_vld;
   assign push        = aligned_vld & ~rst;
   assign out_valid   = (count != '0);
   assign pop         = out_valid & out_ready;
   assign full        = (count == CW'(DEPTH));
   // A pop frees the slot at the edge the new row lands, so a full FIFO still accepts then.
   assign accept      = push & (~full | pop);
   assign out_data    = out_valid ? mem[rd_ptr] : '0;
   assign fifo_count  = count;

   // Row storage; not reset, validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= dly_dat;
      end
   end

   // Pointers, occupancy and sticky flags; a setting event beats clear_flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         misalign <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (accept && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !accept) begin
            count <= count - CW'(1);
         end
         if (push && full && !pop) begin
            overflow <= 1'b1;
         end else if (clear_flags) begin
            overflow <= 1'b0;
         end
         if (partial) begin
            misalign <= 1'b1;
         end else if (clear_flags) begin
            misalign <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_output_deskew_fifo.sv
// Directed bench for output_deskew_fifo: forward and reverse skew, overflow, simultaneous push/pop, flags, reset.
// Latency: checks the state visible one cycle after each driven cycle.
// Backpressure: out_ready is driven per test to fill, hold and drain the FIFO.
module tb_output_deskew_fifo;

   logic              clk;
   logic              rst;
   logic [3:0][15:0]  din;
   logic [3:0]        vin;
   logic [3:0][15:0]  od;
   logic              ov;
   logic              rdy;
   logic [2:0]        cnt;
   logic              ovf;
   logic              mis;
   logic              clr;

   logic [3:0][15:0]  din_r;
   logic [3:0]        vin_r;
   logic [3:0][15:0]  od_r;
   logic              ov_r;
   logic              rdy_r;
   logic [2:0]        cnt_r;
   logic              ovf_r;
   logic              mis_r;
   logic              clr_r;

   int vectors;
   int miscompares;

   output_deskew_fifo #(.N(4), .DW(16), .DEPTH(4), .REVERSE(0)) u_dut (
      .clk(clk), .rst(rst),
      .skewed_data_in(din), .skewed_valid_in(vin),
      .out_data(od), .out_valid(ov), .out_ready(rdy),
      .fifo_count(cnt), .overflow(ovf), .misalign(mis), .clear_flags(clr)
   );

   output_deskew_fifo #(.N(4), .DW(16), .DEPTH(4), .REVERSE(1)) u_rev (
      .clk(clk), .rst(rst),
      .skewed_data_in(din_r), .skewed_valid_in(vin_r),
      .out_data(od_r), .out_valid(ov_r), .out_ready(rdy_r),
      .fifo_count(cnt_r), .overflow(ovf_r), .misalign(mis_r), .clear_flags(clr_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  v;
      logic [63:0] d;
      logic        rdy;
      logic        clr;
      logic        ov;
      logic [63:0] od;
      logic [2:0]  cnt;
      logic        ovf;
      logic        mis;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic [3:0] v, input logic [63:0] d, input logic r, input logic c,
                               input logic eov, input logic [63:0] eod, input logic [2:0] ecnt,
                               input logic eovf, input logic emis);
      vec_t t;
      t.v = v; t.d = d; t.rdy = r; t.clr = c;
      t.ov = eov; t.od = eod; t.cnt = ecnt; t.ovf = eovf; t.mis = emis;
      return t;
   endfunction

   function automatic logic [127:0] es(input logic eov, input logic [63:0] eod, input logic [2:0] ecnt,
                                       input logic eovf, input logic emis);
      return {58'd0, eov, eod, ecnt, eovf, emis};
   endfunction

   function automatic logic [127:0] st();
      return {58'd0, ov, od, cnt, ovf, mis};
   endfunction

   function automatic logic [127:0] st_r();
      return {58'd0, ov_r, od_r, cnt_r, ovf_r, mis_r};
   endfunction

   function automatic logic [15:0] lane_val(input int id, input int i);
      logic [15:0] r;
      r = {id[7:0], i[7:0]};
      return r;
   endfunction

   function automatic logic [63:0] row_val(input int id);
      logic [3:0][15:0] r;
      for (int i = 0; i < 4; i++) r[i] = lane_val(id, i);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Staggered stream of n rows starting at id base; optional reset at cycle cut, ready pulse at cycle rdy_c.
   task automatic stream(input int base, input int n, input int cut, input int rdy_c);
      for (int c = 0; c < n + 3; c++) begin
         step();
         vin = '0;
         din = '0;
         for (int i = 0; i < 4; i++) begin
            if (c - i >= 0 && c - i < n) begin
               vin[i] = 1'b1;
               din[i] = lane_val(base + c - i, i);
            end
         end
         if (rdy_c >= 0) rdy = (c == rdy_c);
         if (c == cut) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            vin = '0;
            din = '0;
            return;
         end
      end
      step();
      vin = '0;
      din = '0;
      if (rdy_c >= 0) rdy = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1; din = '0; vin = '0; rdy = 1'b1; clr = 1'b0;
      din_r = '0; vin_r = '0; rdy_r = 1'b1; clr_r = 1'b0;

      tbl[0]  = mk(4'b0001, 64'h0000_0000_0000_000A, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[1]  = mk(4'b0010, 64'h0000_0000_0014_0000, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[2]  = mk(4'b0100, 64'h0000_001E_0000_0000, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[3]  = mk(4'b1000, 64'h0028_0000_0000_0000, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[4]  = mk(4'b0000, 64'h0, 1, 0, 1, 64'h0028_001E_0014_000A, 3'd1, 0, 0);
      tbl[5]  = mk(4'b0000, 64'h0, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[6]  = mk(4'b0001, 64'h0000_0000_0000_0005, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[7]  = mk(4'b0000, 64'h0, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[8]  = mk(4'b0000, 64'h0, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[9]  = mk(4'b0000, 64'h0, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[10] = mk(4'b0000, 64'h0, 1, 1, 0, 64'h0, 3'd0, 0, 1);
      tbl[11] = mk(4'b0000, 64'h0, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[12] = mk(4'b0001, 64'h0000_0000_0000_0007, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[13] = mk(4'b0000, 64'h0, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[14] = mk(4'b0000, 64'h0, 1, 0, 0, 64'h0, 3'd0, 0, 0);
      tbl[15] = mk(4'b0000, 64'h0, 1, 1, 0, 64'h0, 3'd0, 0, 0);
      tbl[16] = mk(4'b0000, 64'h0, 1, 1, 0, 64'h0, 3'd0, 0, 1);
      tbl[17] = mk(4'b0000, 64'h0, 1, 0, 0, 64'h0, 3'd0, 0, 0);

      repeat (3) step();
      chk("reset_state", st(), es(0, 64'h0, 3'd0, 0, 0));
      rst = 1'b0;

      // single row, lone-lane misalign, clear vs. set priority
      for (int k = 0; k < 18; k++) begin
         step();
         vin = tbl[k].v; din = tbl[k].d; rdy = tbl[k].rdy; clr = tbl[k].clr;
         chk($sformatf("vec%0d", k), st(), es(tbl[k].ov, tbl[k].od, tbl[k].cnt, tbl[k].ovf, tbl[k].mis));
      end
      step();
      vin = '0; din = '0; clr = 1'b0;

      // five rows into a four-deep FIFO with no consumer
      rdy = 1'b0;
      stream(1, 5, -1, -1);
      chk("ovf_full", st(), es(1, row_val(1), 3'd4, 1, 0));
      rdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("ovf_drain%0d", k), st(), es(1, row_val(k), 3'(5 - k), 1, 0));
         step();
      end
      chk("ovf_empty", st(), es(0, 64'h0, 3'd0, 1, 0));
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("ovf_clear", st(), es(0, 64'h0, 3'd0, 0, 0));

      // full FIFO, push coinciding with pop
      rdy = 1'b0;
      stream(16, 4, -1, -1);
      chk("pp_full", st(), es(1, row_val(16), 3'd4, 0, 0));
      stream(32, 1, -1, 3);
      chk("pp_after", st(), es(1, row_val(17), 3'd4, 0, 0));
      rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("pp_drain%0d", k), st(),
             es(1, row_val(k == 3 ? 32 : 17 + k), 3'(4 - k), 0, 0));
         step();
      end
      chk("pp_empty", st(), es(0, 64'h0, 3'd0, 0, 0));

      // reverse skew: lane 3 first, lane 0 last
      for (int c = 0; c < 4; c++) begin
         vin_r = '0;
         din_r = '0;
         vin_r[3 - c] = 1'b1;
         din_r[3 - c] = lane_val(64, 3 - c);
         chk($sformatf("rev_c%0d", c), st_r(), es(0, 64'h0, 3'd0, 0, 0));
         step();
      end
      vin_r = '0;
      din_r = '0;
      chk("rev_row", st_r(), es(1, row_val(64), 3'd1, 0, 0));
      step();
      chk("rev_gone", st_r(), es(0, 64'h0, 3'd0, 0, 0));

      // reset with rows queued, rows in flight and a flag set
      rdy = 1'b0;
      stream(40, 2, -1, -1);
      chk("rst_queued", st(), es(1, row_val(40), 3'd2, 0, 0));
      vin[0] = 1'b1;
      din[0] = 16'h0055;
      step();
      vin = '0;
      din = '0;
      repeat (3) step();
      chk("rst_mis_set", st(), es(1, row_val(40), 3'd2, 0, 1));
      stream(48, 2, 3, -1);
      chk("rst_cleared", st(), es(0, 64'h0, 3'd0, 0, 0));
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("rst_idle%0d", k), st(), es(0, 64'h0, 3'd0, 0, 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
